// File: rtl/sfp_norm_pkg.sv
// Shared widths, defaults and FSM encoding for the normalisation stage.
package sfp_pkg;
  localparam int BW_PSUM    = 20;
  localparam int COL        = 8;
  localparam int FRAC_BITS  = 8;
  localparam int FIFO_DEPTH = 8;

  localparam int SUM_W = BW_PSUM + 4;
  localparam int TOT_W = BW_PSUM + 5;
  localparam int DIV_W = BW_PSUM + FRAC_BITS;
  localparam int CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LSUM = 3'd1,
    EXCH = 3'd2,
    DIV  = 3'd3,
    PUSH = 3'd4
  } state_e;
endpackage

// File: rtl/sfp_norm_if.sv
// Psum input, peer-sum link and output FIFO signals of one normalisation stage.
interface sfp_norm_if
  import sfp_pkg::*;
#(
  parameter int bw_psum = BW_PSUM,
  parameter int col     = COL
);
  logic                     norm_start;
  logic                     norm_valid;
  logic [bw_psum*col-1:0]   psum_in;
  logic [bw_psum+3:0]       sum_out;
  logic                     sum_out_valid;
  logic [bw_psum+3:0]       sum_in;
  logic                     sum_in_valid;
  logic                     sfp_rd;
  logic [bw_psum*col-1:0]   out;
  logic                     out_valid;
  logic                     fifo_full;
  logic                     busy;

  modport master (
    output norm_start, norm_valid, psum_in, sum_in, sum_in_valid, sfp_rd,
    input  sum_out, sum_out_valid, out, out_valid, fifo_full, busy
  );

  modport slave (
    input  norm_start, norm_valid, psum_in, sum_in, sum_in_valid, sfp_rd,
    output sum_out, sum_out_valid, out, out_valid, fifo_full, busy
  );
endinterface

// File: rtl/sfp_norm_div_lane.sv
// One lane: (|lane| << frac_bits) / divisor by restoring division, one quotient
// bit per step, sign reapplied at the end (truncation toward zero).
module sfp_div_lane
  import sfp_pkg::*;
#(
  parameter int bw_psum   = BW_PSUM,
  parameter int frac_bits = FRAC_BITS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [bw_psum-1:0] lane_i,
  input  logic [bw_psum+4:0] divisor_i,
  output logic [bw_psum-1:0] q_o
);
  localparam int DW = bw_psum + frac_bits;
  localparam int TW = bw_psum + 5;

  logic [DW-1:0]   dq_q, dq_d;     // dividend shifts out the top, quotient shifts in
  logic [TW-1:0]   rem_q, rem_d;
  logic [TW-1:0]   dvs_q;
  logic            neg_q, zero_q;
  logic [bw_psum-1:0] mag;
  logic [TW:0]     shifted;
  logic [TW+1:0]   diff;

  assign mag     = lane_i[bw_psum-1] ? -lane_i : lane_i;
  assign shifted = {rem_q, dq_q[DW-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_q};

  always_comb begin
    rem_d = rem_q;
    dq_d  = dq_q;
    if (step_i) begin
      if (!diff[TW+1]) begin
        rem_d = diff[TW-1:0];
        dq_d  = {dq_q[DW-2:0], 1'b1};
      end else begin
        rem_d = shifted[TW-1:0];
        dq_d  = {dq_q[DW-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dq_q   <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (start_i) begin
      dq_q   <= {mag, {frac_bits{1'b0}}};
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      neg_q  <= lane_i[bw_psum-1];
      zero_q <= (divisor_i == '0);
    end else begin
      dq_q  <= dq_d;
      rem_q <= rem_d;
    end
  end

  // A zero divisor would yield all-ones quotient bits; force a clean zero instead.
  assign q_o = zero_q ? '0 : (neg_q ? -dq_q[bw_psum-1:0] : dq_q[bw_psum-1:0]);
endmodule

// File: rtl/sfp_norm.sv
// Normalisation stage: local |sum|, peer exchange, per-lane division by the
// two-core total, and a show-ahead output FIFO.
module sfp_norm
  import sfp_pkg::*;
#(
  parameter int bw_psum    = BW_PSUM,
  parameter int col        = COL,
  parameter int frac_bits  = FRAC_BITS,
  parameter int fifo_depth = FIFO_DEPTH
) (
  input logic        clk,
  input logic        reset_n,
  sfp_norm_if.slave  nif
);
  localparam int SW = bw_psum + 4;
  localparam int TW = bw_psum + 5;
  localparam int DW = bw_psum + frac_bits;
  localparam int CW = $clog2(DW + 1);
  localparam int AW = $clog2(fifo_depth);

  state_e                          state_q, state_d;
  logic [col-1:0][bw_psum-1:0]     psum_q, res;
  logic signed [SW-1:0]            lsum;
  logic [SW-1:0]                   lsum_abs, sum_q, peer_q, peer_v;
  logic                            sov_q, peer_held_q;
  logic [TW-1:0]                   total;
  logic [CW-1:0]                   cnt_q;
  logic                            exch_go, div_step;

  logic [col*bw_psum-1:0]          mem_q [fifo_depth];
  logic [AW-1:0]                   wr_q, rd_q;
  logic [AW:0]                     fcnt_q;
  logic                            full, empty, push, pop;

  always_comb begin
    lsum = '0;
    for (int k = 0; k < col; k++) lsum = lsum + SW'(signed'(psum_q[k]));
  end
  assign lsum_abs = lsum[SW-1] ? -lsum : lsum;

  // A pulse arriving in the same cycle EXCH is waiting is used directly.
  assign peer_v   = nif.sum_in_valid ? nif.sum_in : peer_q;
  assign total    = TW'(sum_q) + TW'(peer_v);
  assign exch_go  = (state_q == EXCH) && (peer_held_q || nif.sum_in_valid);
  assign div_step = (state_q == DIV);

  assign full  = (fcnt_q == (AW+1)'(fifo_depth));
  assign empty = (fcnt_q == '0);
  assign push  = (state_q == PUSH) && nif.norm_start && (!full || nif.sfp_rd);
  assign pop   = nif.sfp_rd && !empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (nif.norm_valid) state_d = LSUM;
      LSUM:    state_d = EXCH;
      EXCH:    if (exch_go) state_d = DIV;
      DIV:     if (cnt_q == CW'(1)) state_d = PUSH;
      PUSH:    if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!nif.norm_start) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      psum_q      <= '0;
      sum_q       <= '0;
      sov_q       <= 1'b0;
      peer_q      <= '0;
      peer_held_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && nif.norm_start && nif.norm_valid) psum_q <= nif.psum_in;
      sov_q <= 1'b0;
      if (state_q == LSUM && nif.norm_start) begin
        sum_q <= lsum_abs;
        sov_q <= 1'b1;
      end
      if (nif.sum_in_valid) peer_q <= nif.sum_in;
      if (!nif.norm_start || exch_go) peer_held_q <= 1'b0;
      else if (nif.sum_in_valid)      peer_held_q <= 1'b1;
      if (exch_go)             cnt_q <= CW'(DW);
      else if (state_q == DIV) cnt_q <= cnt_q - CW'(1);
    end
  end

  for (genvar k = 0; k < col; k++) begin : g_lane
    sfp_div_lane #(.bw_psum(bw_psum), .frac_bits(frac_bits)) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .start_i   (exch_go),
      .step_i    (div_step),
      .lane_i    (psum_q[k]),
      .divisor_i (total),
      .q_o       (res[k])
    );
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= res;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)      fcnt_q <= fcnt_q + (AW+1)'(1);
      else if (pop && !push) fcnt_q <= fcnt_q - (AW+1)'(1);
    end
  end

  assign nif.sum_out       = sum_q;
  assign nif.sum_out_valid = sov_q;
  assign nif.out           = empty ? '0 : mem_q[rd_q];
  assign nif.out_valid     = !empty;
  assign nif.fifo_full     = full;
  assign nif.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_sfp_norm.sv
// Bench for sfp_norm: directed table, randomized vectors against an arithmetic
// reference, and hand sequences for FIFO full, abort and mid-run reset.
module tb_sfp_norm;
  localparam int BW = 20, COL = 8, FR = 8, VW = BW * COL;
  localparam int LAT = 3 + BW + FR;

  typedef logic [COL-1:0][BW-1:0] vecp_t;
  typedef struct packed {
    vecp_t lanes;
    int    peer;
    int    pe;
    int    exp_sum;
    vecp_t exp_q;
  } dvec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0, n_err = 0;

  sfp_norm_if #(.bw_psum(BW), .col(COL)) nif ();
  sfp_norm #(.bw_psum(BW), .col(COL), .frac_bits(FR), .fifo_depth(8)) dut (
    .clk(clk), .reset_n(reset_n), .nif(nif)
  );

  always #5 clk = ~clk;

  dvec_t  tbl [7];
  vecp_t  l, eq, q[$];
  longint so;
  bit     ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vecp_t pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int a [8];
    vecp_t v;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int k = 0; k < COL; k++) v[k] = BW'(a[k]);
    return v;
  endfunction

  // Reference: plain integer arithmetic on the normalisation rules.
  function automatic void model(input vecp_t v, input longint peer, output longint s_abs, output vecp_t r);
    longint s, tot, m, x, lane;
    s = 0;
    for (int k = 0; k < COL; k++) s += longint'(signed'(v[k]));
    s_abs = (s < 0) ? -s : s;
    tot = s_abs + peer;
    for (int k = 0; k < COL; k++) begin
      lane = longint'(signed'(v[k]));
      m = (lane < 0) ? -lane : lane;
      x = (tot == 0) ? 0 : (m * (64'sd1 << FR)) / tot;
      if (lane < 0) x = -x;
      r[k] = x[BW-1:0];
    end
  endfunction

  function automatic vecp_t rand_vec();
    vecp_t v;
    int mode;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < COL; k++) begin
      case (mode)
        0:       v[k] = BW'($urandom_range(0, 6000) - 3000);
        1:       v[k] = BW'($urandom);
        default: v[k] = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(0, 400) - 200) : '0;
      endcase
    end
    return v;
  endfunction

  task automatic pop_one();
    nif.sfp_rd = 1'b1;
    tick();
    nif.sfp_rd = 1'b0;
  endtask

  // pe: edge index (after norm_valid) at which the peer pulse is sampled; negative = that many cycles early.
  task automatic run_one(input string nm, input vecp_t v, input int peer, input int pe,
                         input vecp_t exp_q, input longint exp_sum);
    int pulses, lat, exp_lat;
    logic [BW+3:0] so_seen;
    if (pe < 0) begin
      nif.sum_in = (BW+4)'(peer);
      nif.sum_in_valid = 1'b1;
      tick();
      nif.sum_in_valid = 1'b0;
      repeat (-pe - 1) tick();
    end
    nif.psum_in = v;
    nif.norm_valid = 1'b1;
    tick();
    nif.norm_valid = 1'b0;
    pulses = 0; lat = 0; so_seen = '0;
    for (int k = 1; k <= 200; k++) begin
      nif.sum_in_valid = (k == pe);
      if (k == pe) nif.sum_in = (BW+4)'(peer);
      nif.norm_valid = 1'($urandom_range(0, 1));
      nif.psum_in = rand_vec();
      tick();
      nif.sum_in_valid = 1'b0;
      nif.norm_valid = 1'b0;
      if (nif.sum_out_valid) begin
        pulses++;
        so_seen = nif.sum_out;
      end
      if (k == 1) chk({nm, "_busy"}, VW'(nif.busy), VW'(1));
      if (nif.out_valid) begin
        lat = k;
        break;
      end
    end
    exp_lat = LAT + ((pe > 2) ? pe - 2 : 0);
    chk({nm, "_pulses"}, VW'(pulses), VW'(1));
    chk({nm, "_sum"}, VW'(so_seen), VW'(exp_sum));
    chk({nm, "_latency"}, VW'(lat), VW'(exp_lat));
    chk({nm, "_out"}, nif.out, exp_q);
    pop_one();
    chk({nm, "_empty"}, VW'(nif.out_valid), VW'(0));
  endtask

  task automatic start_vec(input vecp_t v, input int peer);
    nif.psum_in = v;
    nif.norm_valid = 1'b1;
    tick();
    nif.norm_valid = 1'b0;
    tick();
    nif.sum_in = (BW+4)'(peer);
    nif.sum_in_valid = 1'b1;
    tick();
    nif.sum_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit done);
    done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (!nif.busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      nif.norm_start = 1'($urandom); nif.norm_valid = 1'($urandom);
      nif.psum_in = rand_vec(); nif.sum_in = (BW+4)'($urandom);
      nif.sum_in_valid = 1'($urandom); nif.sfp_rd = 1'($urandom);
      tick();
    end
    chk("rst_out", nif.out, '0);
    chk("rst_out_valid", VW'(nif.out_valid), VW'(0));
    chk("rst_sov", VW'(nif.sum_out_valid), VW'(0));
    chk("rst_busy", VW'(nif.busy), VW'(0));
    chk("rst_full", VW'(nif.fifo_full), VW'(0));
    chk("rst_sum_out", VW'(nif.sum_out), VW'(0));
    nif.norm_start = 1'b1; nif.norm_valid = 1'b0; nif.psum_in = '0;
    nif.sum_in = '0; nif.sum_in_valid = 1'b0; nif.sfp_rd = 1'b0;
    reset_n = 1'b1;
    tick();

    // Directed table with hand-derived results.
    tbl[0] = '{pack8(100,-50,30,20,0,0,0,0), 156, 2, 100, pack8(100,-50,30,20,0,0,0,0)};
    tbl[1] = '{pack8(10,-7,0,0,0,0,0,0), 0, 2, 3, pack8(853,-597,0,0,0,0,0,0)};
    tbl[2] = '{pack8(0,0,0,0,0,0,0,0), 0, 2, 0, pack8(0,0,0,0,0,0,0,0)};
    tbl[3] = '{pack8(100,-50,30,20,0,0,0,0), 156, -5, 100, pack8(100,-50,30,20,0,0,0,0)};
    tbl[4] = '{pack8(100,-50,30,20,0,0,0,0), 156, 42, 100, pack8(100,-50,30,20,0,0,0,0)};
    tbl[5] = '{pack8(-1000,-24,0,0,0,0,0,0), 0, 2, 1024, pack8(-250,-6,0,0,0,0,0,0)};
    tbl[6] = '{pack8(5000,-4999,0,0,0,0,0,0), 0, 2, 1, pack8(231424,-231168,0,0,0,0,0,0)};
    for (int i = 0; i < 7; i++)
      run_one($sformatf("tbl%0d", i), tbl[i].lanes, tbl[i].peer, tbl[i].pe,
              tbl[i].exp_q, longint'(tbl[i].exp_sum));

    // Randomized vectors against the reference.
    for (int i = 0; i < 20; i++) begin
      int peer, pe;
      l = rand_vec();
      peer = ($urandom_range(0, 3) == 0) ? 0 : int'(($urandom & 32'hFFFFFF) >> $urandom_range(0, 23));
      case ($urandom_range(0, 3))
        0:       pe = -3;
        1:       pe = 3;
        2:       pe = 7;
        default: pe = 2;
      endcase
      model(l, longint'(peer), so, eq);
      run_one($sformatf("rnd%0d", i), l, peer, pe, eq, so);
    end

    // Fill the FIFO, stall the 9th vector, release with one read, drain in order.
    q.delete();
    for (int i = 0; i < 8; i++) begin
      l = rand_vec();
      model(l, 64'd300, so, eq);
      q.push_back(eq);
      start_vec(l, 300);
      wait_idle(60, ok);
      chk("fill_idle", VW'(ok), VW'(1));
    end
    chk("fill_full", VW'(nif.fifo_full), VW'(1));
    l = rand_vec();
    model(l, 64'd9, so, eq);
    q.push_back(eq);
    start_vec(l, 9);
    repeat (40) tick();
    chk("stall_busy", VW'(nif.busy), VW'(1));
    chk("stall_head", nif.out, q[0]);
    pop_one();
    void'(q.pop_front());
    chk("stall_released", VW'(nif.busy), VW'(0));
    chk("stall_still_full", VW'(nif.fifo_full), VW'(1));
    for (int i = 0; i < 9 && q.size() > 0; i++) begin
      chk($sformatf("drain%0d", i), nif.out, q.pop_front());
      pop_one();
    end
    chk("drain_empty", VW'(nif.out_valid), VW'(0));
    chk("drain_out_zero", nif.out, '0);

    // Abort mid-DIV with one entry held in the FIFO.
    l = rand_vec();
    model(l, 64'd40, so, eq);
    start_vec(l, 40);
    wait_idle(60, ok);
    start_vec(rand_vec(), 11);
    repeat (8) tick();
    nif.norm_start = 1'b0;
    tick();
    nif.norm_start = 1'b1;
    chk("abort_idle", VW'(nif.busy), VW'(0));
    repeat (40) tick();
    chk("abort_keep_head", nif.out, eq);
    pop_one();
    chk("abort_no_push", VW'(nif.out_valid), VW'(0));

    // Abort in LSUM: no sum_out_valid pulse.
    nif.psum_in = rand_vec(); nif.norm_valid = 1'b1;
    tick();
    nif.norm_valid = 1'b0; nif.norm_start = 1'b0;
    tick();
    nif.norm_start = 1'b1;
    chk("lsum_abort_sov", VW'(nif.sum_out_valid), VW'(0));
    chk("lsum_abort_busy", VW'(nif.busy), VW'(0));

    // A held peer value is discarded when norm_start drops.
    nif.sum_in = 24'd77; nif.sum_in_valid = 1'b1;
    tick();
    nif.sum_in_valid = 1'b0; nif.norm_start = 1'b0;
    tick();
    nif.norm_start = 1'b1;
    l = rand_vec();
    model(l, 64'd5, so, eq);
    nif.psum_in = l; nif.norm_valid = 1'b1;
    tick();
    nif.norm_valid = 1'b0;
    repeat (40) tick();
    chk("stale_peer_wait", VW'(nif.busy), VW'(1));
    nif.sum_in = 24'd5; nif.sum_in_valid = 1'b1;
    tick();
    nif.sum_in_valid = 1'b0;
    wait_idle(60, ok);
    chk("stale_peer_done", VW'(ok), VW'(1));
    chk("stale_peer_out", nif.out, eq);

    // Reset mid-operation empties the FIFO and idles the FSM.
    start_vec(rand_vec(), 3);
    repeat (5) tick();
    reset_n = 1'b0;
    #2;
    chk("midrst_busy", VW'(nif.busy), VW'(0));
    chk("midrst_out_valid", VW'(nif.out_valid), VW'(0));
    chk("midrst_out", nif.out, '0);
    chk("midrst_sum_out", VW'(nif.sum_out), VW'(0));
    tick();
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
